// File: rtl/crt_pkg.sv
// Shared types and defaults for the 1-bpp double-buffered CRT bitmap overlay.
package crt_pkg;

  localparam int unsigned DEF_COLS = 40;
  localparam int unsigned DEF_ROWS = 6;
  localparam int unsigned DEPTH    = DEF_COLS * DEF_ROWS;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    PENDING
  } crt_state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  function automatic int unsigned lin_addr(input int unsigned row, input int unsigned col,
                                           input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/crt_bitmap_ram.sv
// Two-bank 1-bit bitmap store: one synchronous read port, one write port, bank chosen per port.
module crt_bitmap_ram #(
  parameter int unsigned DEPTH = 240,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data
);

  logic mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/crt_bitmap_overlay.sv
// Double-buffered bitmap overlay: back-bank writer FSM plus a 2-stage render pipeline that
// keeps colour, sync and DE aligned.
module crt_bitmap_overlay
  import crt_pkg::*;
#(
  parameter int unsigned CORDW      = 10,
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned SCALE_LOG2 = 3,
  parameter int unsigned X0         = 0,
  parameter int unsigned Y0         = 0,
  parameter int unsigned CW         = 1,
  parameter logic [2:0]  FG         = 3'b100,
  parameter logic [2:0]  BG         = 3'b000
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             frame_start,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_x,
  input  logic [7:0]       wr_y,
  input  logic             wr_bit,
  input  logic             commit,
  output logic             commit_drop,
  output logic             wr_oob,
  output logic [CW-1:0]    r,
  output logic [CW-1:0]    g,
  output logic [CW-1:0]    b,
  output logic             hsync,
  output logic             vsync,
  output logic             de
);

  localparam int unsigned BANK_DEPTH = COLS * ROWS;
  localparam int unsigned AW         = $clog2(BANK_DEPTH);
  localparam logic [CORDW:0] X_LO = (CORDW+1)'(X0);
  localparam logic [CORDW:0] X_HI = (CORDW+1)'(X0 + (COLS << SCALE_LOG2));
  localparam logic [CORDW:0] Y_LO = (CORDW+1)'(Y0);
  localparam logic [CORDW:0] Y_HI = (CORDW+1)'(Y0 + (ROWS << SCALE_LOG2));

  crt_state_e    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          bank_sel_q, bank_sel_d;
  logic          front_valid_q, front_valid_d;
  logic          commit_drop_q, commit_drop_d;
  logic          wr_oob_q, wr_oob_d;

  logic          wr_accept, wr_in_range;
  logic [AW-1:0] wr_addr;
  logic          ram_we, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_waddr;

  assign wr_ready    = (state_q == IDLE);
  assign wr_accept   = wr_valid & wr_ready;
  assign wr_in_range = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
  assign wr_addr     = AW'(lin_addr(32'(wr_y), 32'(wr_x), COLS));

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    bank_sel_d    = bank_sel_q;
    front_valid_d = front_valid_q;
    commit_drop_d = 1'b0;
    wr_oob_d      = wr_accept & ~wr_in_range;
    ram_we        = 1'b0;
    ram_waddr     = clr_cnt_q;
    ram_wdata     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ram_we        = 1'b1;
        commit_drop_d = commit;
        if (clr_cnt_q == AW'(BANK_DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      IDLE: begin
        if (wr_accept && wr_in_range) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr;
          ram_wdata = wr_bit;
        end
        if (commit) begin
          if (frame_start) begin
            bank_sel_d    = ~bank_sel_q;
            front_valid_d = 1'b1;
            state_d       = CLEAR;
          end else begin
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        commit_drop_d = commit;
        if (frame_start) begin
          bank_sel_d    = ~bank_sel_q;
          front_valid_d = 1'b1;
          state_d       = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q       <= CLEAR;
      clr_cnt_q     <= '0;
      bank_sel_q    <= 1'b0;
      front_valid_q <= 1'b0;
      commit_drop_q <= 1'b0;
      wr_oob_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      bank_sel_q    <= bank_sel_d;
      front_valid_q <= front_valid_d;
      commit_drop_q <= commit_drop_d;
      wr_oob_q      <= wr_oob_d;
    end
  end

  assign commit_drop = commit_drop_q;
  assign wr_oob      = wr_oob_q;

  // Stage 1: window test and bitmap address, computed combinationally into the RAM read.
  logic [CORDW:0]   sx_e, sy_e;
  logic [CORDW-1:0] dx, dy, col, row;
  logic             in_win;
  logic [AW-1:0]    rd_addr;

  assign sx_e    = {1'b0, sx};
  assign sy_e    = {1'b0, sy};
  assign in_win  = de_in && (sx_e >= X_LO) && (sx_e < X_HI) && (sy_e >= Y_LO) && (sy_e < Y_HI);
  assign dx      = sx - CORDW'(X0);
  assign dy      = sy - CORDW'(Y0);
  assign col     = dx >> SCALE_LOG2;
  assign row     = dy >> SCALE_LOG2;
  assign rd_addr = in_win ? AW'(lin_addr(32'(row), 32'(col), COLS)) : '0;

  // Read with the next-state bank so the first pixel after a swap comes from the new front.
  crt_bitmap_ram #(
    .DEPTH (BANK_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk_pix),
    .rd_bank (bank_sel_d),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata),
    .wr_en   (ram_we),
    .wr_bank (~bank_sel_q),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata)
  );

  logic win1_q, fv1_q, de1_q, hs1_q, vs1_q;
  logic de2_q, hs2_q, vs2_q;
  rgb_t rgb_q, rgb_d;

  always_comb begin
    rgb_d = '0;
    if (win1_q) begin
      rgb_d = (fv1_q && ram_rdata) ? rgb_t'(FG) : rgb_t'(BG);
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      win1_q <= 1'b0;
      fv1_q  <= 1'b0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      de2_q  <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      rgb_q  <= '0;
    end else begin
      win1_q <= in_win;
      fv1_q  <= front_valid_d;
      de1_q  <= de_in;
      hs1_q  <= hsync_in;
      vs1_q  <= vsync_in;
      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      rgb_q  <= rgb_d;
    end
  end

  assign r     = {CW{rgb_q.r}};
  assign g     = {CW{rgb_q.g}};
  assign b     = {CW{rgb_q.b}};
  assign hsync = hs2_q;
  assign vsync = vs2_q;
  assign de    = de2_q;

endmodule

// File: tb/tb_crt_bitmap_overlay.sv
// Directed bench for crt_bitmap_overlay: drives the timing inputs by hand and probes pixels.
module tb_crt_bitmap_overlay;

  localparam logic [2:0] FG  = 3'b100;
  localparam logic [2:0] BG  = 3'b000;
  localparam logic [2:0] OFF = 3'b000;
  // {wr_ready, r, g, b, de, hsync, vsync, commit_drop, wr_oob}
  localparam logic [8:0] RST_VEC = 9'b0_000_0_11_00;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b1;
  logic [9:0] sx = '0, sy = '0;
  logic       de_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, frame_start = 1'b0;
  logic       wr_valid = 1'b0, wr_bit = 1'b0, commit = 1'b0;
  logic [7:0] wr_x = '0, wr_y = '0;
  logic       wr_ready, commit_drop, wr_oob, hsync, vsync, de;
  logic [0:0] r, g, b;

  int n_cmp = 0;
  int n_bad = 0;

  crt_bitmap_overlay dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .sx          (sx),
    .sy          (sy),
    .de_in       (de_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .frame_start (frame_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_bit      (wr_bit),
    .commit      (commit),
    .commit_drop (commit_drop),
    .wr_oob      (wr_oob),
    .r           (r),
    .g           (g),
    .b           (b),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de)
  );

  always #5 clk_pix = ~clk_pix;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic probe(input int x, input int y, output logic [2:0] rgb);
    sx    = 10'(x);
    sy    = 10'(y);
    de_in = 1'b1;
    step();
    step();
    rgb   = {r, g, b};
    de_in = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int i = 0;
    while (!wr_ready && i < 400) begin
      step();
      i++;
    end
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: wr_ready timeout, got %b want 1", name, wr_ready);
    end
  endtask

  task automatic write_px(input int x, input int y, input logic v, output logic oob);
    wait_ready("write_wait");
    wr_x     = 8'(x);
    wr_y     = 8'(y);
    wr_bit   = v;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    oob      = wr_oob;
  endtask

  task automatic pulse_commit(output logic drop);
    commit = 1'b1;
    step();
    commit = 1'b0;
    drop   = commit_drop;
  endtask

  task automatic frame();
    sx          = '0;
    sy          = '0;
    de_in       = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    de_in       = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] px;
    int early;
    rst_pix = 1'b1;
    step();
    step();
    n_cmp++;
    if ({wr_ready, r, g, b, de, hsync, vsync, commit_drop, wr_oob} !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_values: got %b want %b",
               {wr_ready, r, g, b, de, hsync, vsync, commit_drop, wr_oob}, RST_VEC);
    end
    rst_pix = 1'b0;
    early = 0;
    for (int i = 0; i < 239; i++) begin
      step();
      if (wr_ready !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL clear_ready_low: ready high on %0d cycles, want 0", early);
    end
    step();
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_cycle_241: got %b want 1", wr_ready);
    end
    probe(0, 0, px);
    n_cmp++;
    if (px !== BG) begin
      n_bad++;
      $display("FAIL reset_bg: got %b want %b", px, BG);
    end
    n_cmp++;
    if (de !== 1'b1) begin
      n_bad++;
      $display("FAIL de_delay: got %b want 1", de);
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    step();
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    n_cmp++;
    if ({hsync, vsync} !== 2'b11) begin
      n_bad++;
      $display("FAIL sync_delay1: got %b want 11", {hsync, vsync});
    end
    step();
    n_cmp++;
    if ({hsync, vsync} !== 2'b00) begin
      n_bad++;
      $display("FAIL sync_delay2: got %b want 00", {hsync, vsync});
    end
    step();
    n_cmp++;
    if ({hsync, vsync} !== 2'b11) begin
      n_bad++;
      $display("FAIL sync_delay3: got %b want 11", {hsync, vsync});
    end
  endtask

  task automatic test_write_commit();
    logic oob, drop;
    logic [2:0] px;
    int tbl [10][3] = '{'{0, 0, FG}, '{7, 7, FG}, '{8, 0, BG}, '{0, 8, BG},
                        '{312, 40, FG}, '{319, 47, FG}, '{311, 47, BG}, '{319, 39, BG},
                        '{320, 40, OFF}, '{100, 48, OFF}};
    write_px(0, 0, 1'b1, oob);
    n_cmp++;
    if (oob !== 1'b0) begin
      n_bad++;
      $display("FAIL wc_oob_inrange: got %b want 0", oob);
    end
    write_px(39, 5, 1'b1, oob);
    pulse_commit(drop);
    n_cmp++;
    if ({drop, wr_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL wc_pending: got drop,ready=%b want 00", {drop, wr_ready});
    end
    frame();
    for (int i = 0; i < 10; i++) begin
      probe(tbl[i][0], tbl[i][1], px);
      n_cmp++;
      if (px !== 3'(tbl[i][2])) begin
        n_bad++;
        $display("FAIL wc_px(%0d,%0d): got %b want %b", tbl[i][0], tbl[i][1], px,
                 3'(tbl[i][2]));
      end
    end
  endtask

  task automatic test_oob();
    logic oob, drop;
    logic [2:0] px;
    int tbl [4][3] = '{'{0, 0, FG}, '{0, 8, BG}, '{312, 40, BG}, '{8, 0, BG}};
    write_px(40, 0, 1'b1, oob);
    n_cmp++;
    if (oob !== 1'b1) begin
      n_bad++;
      $display("FAIL oob_x40: got %b want 1", oob);
    end
    write_px(0, 6, 1'b1, oob);
    n_cmp++;
    if (oob !== 1'b1) begin
      n_bad++;
      $display("FAIL oob_y6: got %b want 1", oob);
    end
    write_px(0, 0, 1'b1, oob);
    n_cmp++;
    if (oob !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_inrange: got %b want 0", oob);
    end
    pulse_commit(drop);
    frame();
    for (int i = 0; i < 4; i++) begin
      probe(tbl[i][0], tbl[i][1], px);
      n_cmp++;
      if (px !== 3'(tbl[i][2])) begin
        n_bad++;
        $display("FAIL oob_px(%0d,%0d): got %b want %b", tbl[i][0], tbl[i][1], px,
                 3'(tbl[i][2]));
      end
    end
  endtask

  task automatic test_commit_drop();
    logic oob, drop;
    logic [2:0] px;
    pulse_commit(drop);
    n_cmp++;
    if (drop !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_in_clear: got %b want 1", drop);
    end
    write_px(5, 0, 1'b1, oob);
    pulse_commit(drop);
    n_cmp++;
    if (drop !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_in_idle: got %b want 0", drop);
    end
    pulse_commit(drop);
    n_cmp++;
    if (drop !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_in_pending: got %b want 1", drop);
    end
    frame();
    probe(40, 0, px);
    n_cmp++;
    if (px !== FG) begin
      n_bad++;
      $display("FAIL drop_swap_fg: got %b want %b", px, FG);
    end
    probe(0, 0, px);
    n_cmp++;
    if (px !== BG) begin
      n_bad++;
      $display("FAIL drop_swap_bg: got %b want %b", px, BG);
    end
    pulse_commit(drop);
    frame();
    probe(40, 0, px);
    n_cmp++;
    if ({drop, px} !== {1'b1, FG}) begin
      n_bad++;
      $display("FAIL drop_no_second_swap: got drop,px=%b want %b", {drop, px}, {1'b1, FG});
    end
  endtask

  task automatic test_commit_frame_same();
    logic oob;
    logic [2:0] px;
    int early;
    write_px(1, 0, 1'b1, oob);
    commit      = 1'b1;
    frame_start = 1'b1;
    sx          = '0;
    sy          = '0;
    de_in       = 1'b1;
    step();
    commit      = 1'b0;
    frame_start = 1'b0;
    de_in       = 1'b0;
    n_cmp++;
    if ({commit_drop, wr_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL same_swap: got drop,ready=%b want 00", {commit_drop, wr_ready});
    end
    early = 0;
    for (int i = 0; i < 239; i++) begin
      step();
      if (wr_ready !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL same_clear_low: ready high on %0d cycles, want 0", early);
    end
    step();
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL same_ready_240: got %b want 1", wr_ready);
    end
    probe(8, 0, px);
    n_cmp++;
    if (px !== FG) begin
      n_bad++;
      $display("FAIL same_px_fg: got %b want %b", px, FG);
    end
    probe(40, 0, px);
    n_cmp++;
    if (px !== BG) begin
      n_bad++;
      $display("FAIL same_px_bg: got %b want %b", px, BG);
    end
  endtask

  task automatic test_reset_mid();
    logic oob, drop;
    logic [2:0] px;
    sx    = 10'd8;
    sy    = 10'd0;
    de_in = 1'b1;
    step();
    step();
    n_cmp++;
    if ({r, g, b} !== FG) begin
      n_bad++;
      $display("FAIL mid_pre_fg: got %b want %b", {r, g, b}, FG);
    end
    #2;
    rst_pix = 1'b1;
    #1;
    n_cmp++;
    if ({wr_ready, r, g, b, de, hsync, vsync, commit_drop, wr_oob} !== RST_VEC) begin
      n_bad++;
      $display("FAIL mid_reset_values: got %b want %b",
               {wr_ready, r, g, b, de, hsync, vsync, commit_drop, wr_oob}, RST_VEC);
    end
    step();
    rst_pix = 1'b0;
    de_in   = 1'b0;
    wait_ready("mid_wait");
    probe(8, 0, px);
    n_cmp++;
    if (px !== BG) begin
      n_bad++;
      $display("FAIL mid_after_bg: got %b want %b", px, BG);
    end
    frame();
    probe(8, 0, px);
    n_cmp++;
    if (px !== BG) begin
      n_bad++;
      $display("FAIL mid_frame_nocommit: got %b want %b", px, BG);
    end
    write_px(2, 0, 1'b1, oob);
    pulse_commit(drop);
    frame();
    probe(16, 0, px);
    n_cmp++;
    if (px !== FG) begin
      n_bad++;
      $display("FAIL mid_new_fg: got %b want %b", px, FG);
    end
    probe(8, 0, px);
    n_cmp++;
    if (px !== BG) begin
      n_bad++;
      $display("FAIL mid_old_gone: got %b want %b", px, BG);
    end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_oob();
    test_commit_drop();
    test_commit_frame_same();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
